// File: rtl/pulse_stretch_pkg.sv
// pulse_stretch_pkg: shared state encoding and queue limits for pulse_stretch.
package pulse_stretch_pkg;
   typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
   localparam int PENDING_MAX = 15;
   localparam int PW = $clog2(PENDING_MAX + 1);
   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/pulse_stretch_hold_counter.sv
// hold_counter: loadable down-counter that parks at zero and flags it.
module hold_counter #(
   parameter int W = 2
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] count_d, count_q;
   assign zero = count_q == '0;
   always_comb count_d = load ? load_val : (zero ? count_q : count_q - W'(1));
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) count_q <= '0;
      else          count_q <= count_d;
endmodule

// File: rtl/pulse_stretch.sv
// pulse_stretch: stretches event_in into HOLD_CYCLES-long pulses separated by GAP_CYCLES.
// Define PULSE_STRETCH_QUEUE_EN to queue events arriving while busy instead of dropping them.
module pulse_stretch
   import pulse_stretch_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 2,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic clock,
   input  logic reset_n,
   input  logic event_in,
   output logic output_data,
   output logic busy,
   output logic dropped
);
   localparam int CW = $clog2(imax(HOLD_CYCLES, GAP_CYCLES) + 1);
   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);
   localparam logic OFF = ACTIVE_LOW != 0;
   state_t state_d, state_q;
   logic load, zero, gap_end, chain;
   logic out_d, out_q, busy_d, busy_q, dropped_d, dropped_q;
   logic [CW-1:0] load_val;
`ifdef PULSE_STRETCH_QUEUE_EN
   logic [PW-1:0] pend_d, pend_q;
`endif
   hold_counter #(.W(CW)) u_cnt (
      .clock    (clock),
      .reset_n  (reset_n),
      .load     (load),
      .load_val (load_val),
      .zero     (zero)
   );
   always_comb begin
      gap_end = state_q == GAP && zero;
`ifdef PULSE_STRETCH_QUEUE_EN
      // an event on the gap-end edge is consumed directly, leaving pending unchanged
      chain     = gap_end && (pend_q != '0 || event_in);
      pend_d    = pend_q;
      dropped_d = 1'b0;
      if (chain)
         pend_d = pend_q - PW'(!event_in);
      else if (event_in && state_q != IDLE) begin
         if (pend_q == PW'(PENDING_MAX)) dropped_d = 1'b1;
         else                            pend_d    = pend_q + PW'(1);
      end
`else
      chain     = 1'b0;
      dropped_d = event_in && state_q != IDLE;
`endif
      state_d  = state_q == IDLE ? (event_in ? HOLD : IDLE)
               : state_q == HOLD ? (zero ? GAP : HOLD)
               : gap_end         ? (chain ? HOLD : IDLE)
               :                   GAP;
      load     = state_d != IDLE && (state_d != state_q || chain);
      load_val = state_d == GAP ? GAP_LD : HOLD_LD;
      out_d    = (state_d == HOLD) ^ OFF;
      busy_d   = state_d != IDLE;
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         out_q     <= OFF;
         busy_q    <= 1'b0;
         dropped_q <= 1'b0;
`ifdef PULSE_STRETCH_QUEUE_EN
         pend_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         out_q     <= out_d;
         busy_q    <= busy_d;
         dropped_q <= dropped_d;
`ifdef PULSE_STRETCH_QUEUE_EN
         pend_q    <= pend_d;
`endif
      end
   end
   assign output_data = out_q;
   assign busy        = busy_q;
   assign dropped     = dropped_q;
endmodule

// File: tb/tb_pulse_stretch.sv
// tb_pulse_stretch: random and directed stimulus against a schedule-based model, both output polarities.
module tb_pulse_stretch;
   localparam int H = 4, G = 2, P = H + G, QMAX = 15;
   logic clock = 1'b0, reset_n = 1'b0, event_in = 1'b0;
   logic out1, out0, busy1, busy0, drop1, drop0;
   int vectors = 0, miscompares = 0;
   int n = 0, chain_start = 0, end_c = -1;
   bit drop_next = 1'b0;

   always #5 clock = ~clock;

   pulse_stretch #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .ACTIVE_LOW(1)) u_al1 (
      .clock(clock), .reset_n(reset_n), .event_in(event_in),
      .output_data(out1), .busy(busy1), .dropped(drop1));
   pulse_stretch #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .ACTIVE_LOW(0)) u_al0 (
      .clock(clock), .reset_n(reset_n), .event_in(event_in),
      .output_data(out0), .busy(busy0), .dropped(drop0));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, got, exp, n, $time);
      end
   endtask

   // busy spans chain_start..end_c; each pulse occupies the first H slots of a P-cycle period
   task automatic check_all();
      bit bsy, act;
      bsy = n >= chain_start && n <= end_c;
      act = bsy && ((n - chain_start) % P) < H;
      chk("out_al1", 32'(out1), 32'(!act));
      chk("out_al0", 32'(out0), 32'(act));
      chk("busy_al1", 32'(busy1), 32'(bsy));
      chk("busy_al0", 32'(busy0), 32'(bsy));
      chk("dropped_al1", 32'(drop1), 32'(drop_next));
      chk("dropped_al0", 32'(drop0), 32'(drop_next));
   endtask

   task automatic model_event(input bit ev);
      drop_next = 1'b0;
      if (ev) begin
         if (n > end_c) begin
            chain_start = n + 1;
            end_c       = n + P;
         end else begin
`ifdef PULSE_STRETCH_QUEUE_EN
            if ((end_c - n) % P != 0 && (end_c - n) / P == QMAX) drop_next = 1'b1;
            else end_c += P;
`else
            drop_next = 1'b1;
`endif
         end
      end
   endtask

   task automatic step(input bit ev);
      @(negedge clock);
      check_all();
      event_in = ev;
      model_event(ev);
      @(posedge clock);
      n++;
   endtask

   task automatic async_reset();
      #2 reset_n = 1'b0;
      #1;
      chk("rst_out_al1", 32'(out1), 32'd1);
      chk("rst_out_al0", 32'(out0), 32'd0);
      chk("rst_busy", 32'(busy1), 32'd0);
      chk("rst_dropped", 32'(drop1), 32'd0);
      event_in    = 1'b0;
      chain_start = 0;
      end_c       = -1;
      drop_next   = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      int dens;
      repeat (3) @(posedge clock);
      #1;
      chk("init_out_al1", 32'(out1), 32'd1);
      chk("init_out_al0", 32'(out0), 32'd0);
      chk("init_busy", 32'(busy1), 32'd0);
      chk("init_dropped", 32'(drop1), 32'd0);
      reset_n = 1'b1;
      step(1'b1); repeat (9) step(1'b0);
      step(1'b1); step(1'b0); step(1'b1); repeat (12) step(1'b0);
      step(1'b1); step(1'b0); step(1'b1); step(1'b1); repeat (25) step(1'b0);
      repeat (18) step(1'b1); repeat (120) step(1'b0);
      step(1'b1); step(1'b0); async_reset();
      step(1'b1); repeat (10) step(1'b0);
      repeat (4) begin
         step(1'b1); repeat (P - 1) step(1'b0);
      end
      repeat (20) step(1'b0);
      dens = 30;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) dens = $urandom_range(0, 100);
         if ($urandom_range(0, 499) == 0) async_reset();
         step($urandom_range(0, 99) < dens);
      end
      repeat (120) step(1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
